// File: rtl/wb_pkg.sv
// Shared types for the write-back/commit stage: source select, FSM states and
// the default-width pipeline entry layout.
package wb_pkg;

  localparam int WB_DATA_W = 16;
  localparam int WB_ADDR_W = 3;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_MEM  = 2'd1,
    WB_LINK = 2'd2,
    WB_BAD  = 2'd3
  } wb_sel_t;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_FAULT  = 2'd2
  } wb_state_t;

  // Entry layout at the default widths; the stage keeps a parameter-sized twin.
  typedef struct packed {
    wb_sel_t                sel;
    logic [WB_DATA_W-1:0]   alu;
    logic [WB_DATA_W-1:0]   mem;
    logic [WB_DATA_W-1:0]   pc2;
    logic                   wrEn;
    logic [WB_ADDR_W-1:0]   wrAddr;
    logic                   halt;
  } wb_entry_t;

endpackage

// File: rtl/wb_src_mux.sv
// Write-back source select: ALU, memory or link value; the unused encoding
// yields zero data and raises the illegal flag.
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [1:0]        sel,
  input  logic [DATA_W-1:0] alu,
  input  logic [DATA_W-1:0] mem,
  input  logic [DATA_W-1:0] pc2,
  output logic [DATA_W-1:0] data,
  output logic              illegal
);

  always_comb begin
    data    = '0;
    illegal = 1'b0;
    case (wb_sel_t'(sel))
      WB_ALU:  data = alu;
      WB_MEM:  data = mem;
      WB_LINK: data = pc2;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_commit_pipe.sv
// Write-back/commit stage: one-entry pipeline register feeding the regfile write
// port, a bypass port and a retire counter. Optional X/Z input checking: WB_XCHECK_EN.
module wb_commit_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 3,
  parameter int CNT_W      = 32,
  parameter int R0_IS_ZERO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_wb_sel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_mem,
  input  logic [DATA_W-1:0] in_pc2,
  input  logic              in_wr_en,
  input  logic [ADDR_W-1:0] in_wr_addr,
  input  logic              in_halt,
  input  logic              rf_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_data,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              halted,
  output logic              err
);

  typedef struct packed {
    wb_sel_t           sel;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [DATA_W-1:0] pc2;
    logic              wrEn;
    logic [ADDR_W-1:0] wrAddr;
    logic              halt;
  } entry_t;

  entry_t            entryReg;
  logic              validReg;
  wb_state_t         stateReg, stateNext;
  logic [CNT_W-1:0]  retireCntReg;

  logic [DATA_W-1:0] heldData;
  logic              heldIllegal;
  logic              isRun, suppress, willWrite;
  logic              selFault, faultNow, commit, accept, xHit;

  wb_src_mux #(.DATA_W(DATA_W)) uHeldMux (
    .sel     (entryReg.sel),
    .alu     (entryReg.alu),
    .mem     (entryReg.mem),
    .pc2     (entryReg.pc2),
    .data    (heldData),
    .illegal (heldIllegal)
  );

  assign isRun     = (stateReg == ST_RUN);
  assign suppress  = (R0_IS_ZERO != 0) && (entryReg.wrAddr == '0);
  assign willWrite = entryReg.wrEn & ~suppress & ~heldIllegal;

  // An illegal select is only acted on when the entry would otherwise commit.
  assign selFault = validReg & rf_ready & isRun & heldIllegal;
  assign commit   = validReg & rf_ready & isRun & ~selFault;

  // A retiring HALT must not let a younger entry slip in behind it.
  assign in_ready = isRun & (~validReg | (commit & ~entryReg.halt));
  assign accept   = in_valid & in_ready;

`ifdef WB_XCHECK_EN
  logic [DATA_W-1:0] inData;
  logic              unusedInIllegal;

  wb_src_mux #(.DATA_W(DATA_W)) uInMux (
    .sel     (in_wb_sel),
    .alu     (in_alu),
    .mem     (in_mem),
    .pc2     (in_pc2),
    .data    (inData),
    .illegal (unusedInIllegal)
  );

  // Reduction XOR turns any X/Z bit into X; only meaningful in 4-state simulation.
  assign xHit = accept & ((^{in_wb_sel, in_wr_en, in_halt, inData}) === 1'bx);
`else
  assign xHit = 1'b0;
`endif

  assign faultNow = selFault | xHit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validReg     <= 1'b0;
      entryReg     <= '0;
      retireCntReg <= '0;
    end else begin
      if (accept && !xHit) begin
        validReg <= 1'b1;
        entryReg <= '{sel:    wb_sel_t'(in_wb_sel),
                      alu:    in_alu,
                      mem:    in_mem,
                      pc2:    in_pc2,
                      wrEn:   in_wr_en,
                      wrAddr: in_wr_addr,
                      halt:   in_halt};
      end else if (commit) begin
        validReg <= 1'b0;
      end
      if (commit) begin
        retireCntReg <= retireCntReg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= ST_RUN;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      ST_RUN: begin
        if (faultNow) begin
          stateNext = ST_FAULT;
        end else if (commit && entryReg.halt) begin
          stateNext = ST_HALTED;
        end
      end
      default: stateNext = stateReg;
    endcase
  end

  assign rf_we      = commit & willWrite;
  assign rf_addr    = entryReg.wrAddr;
  assign rf_data    = heldData;
  assign fwd_valid  = validReg & isRun & willWrite;
  assign fwd_addr   = entryReg.wrAddr;
  assign fwd_data   = heldData;
  assign retire_cnt = retireCntReg;
  assign halted     = (stateReg == ST_HALTED);
  assign err        = (stateReg == ST_FAULT);

endmodule
